// File: rtl/rhythm_hero_pkg.sv
// Shared constants and types for the score display path: segment patterns,
// controller state encoding and a power-of-ten helper for the saturation limit.
package rhythm_hero_pkg;

  localparam int DIGIT_W = 4;

  // Active-low segment patterns, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    DRIVE  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/score_display_ctrl_if.sv
// Load handshake and display outputs between the scoring logic (master)
// and the score display controller (slave).
interface score_display_ctrl_if #(
  parameter int SCORE_W    = 16,
  parameter int NUM_DIGITS = 5
);
  logic [SCORE_W-1:0]      score;
  logic                    score_valid;
  logic                    ready;
  logic                    done;
  logic                    overflow;
  logic [7*NUM_DIGITS-1:0] hex_out;

  modport master (output score, score_valid, input ready, done, overflow, hex_out);
  modport slave  (input score, score_valid, output ready, done, overflow, hex_out);
endinterface

// File: rtl/seven_segment.sv
// BCD digit to active-low seven-segment decoder; non-decimal codes go blank.
module seven_segment
  import rhythm_hero_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [6:0]         seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display_ctrl.sv
// Binary score to seven-segment display: serial double dabble, then one shared
// decoder walks the digits MSD first into shadow registers, committed together.
module score_display_ctrl
  import rhythm_hero_pkg::*;
#(
  parameter int SCORE_W    = 16,
  parameter int NUM_DIGITS = 5,
  parameter int BLANK_LZ   = 1
) (
  input logic                clk,
  input logic                rst,
  score_display_ctrl_if.slave bus
);

  localparam int BCD_W = DIGIT_W * NUM_DIGITS;
  localparam int CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

  state_t              state_reg;
  logic [SCORE_W-1:0]  bin_reg;
  logic [BCD_W-1:0]    bcd_reg;
  logic [BCD_W-1:0]    bcd_adj;
  logic [CNT_W-1:0]    bit_cnt_reg;
  logic [IDX_W-1:0]    dig_idx_reg;
  logic                seen_nz_reg;
  logic                sat_reg;
  logic                done_reg;
  logic                overflow_reg;
  logic [6:0]          shadow_reg [NUM_DIGITS];
  logic [6:0]          hex_reg    [NUM_DIGITS];
  logic [7*NUM_DIGITS-1:0] hex_flat;

  logic [DIGIT_W-1:0]  nibble [NUM_DIGITS];
  logic [DIGIT_W-1:0]  cur_nibble;
  logic [6:0]          dec_seg;
  logic [6:0]          wr_seg;
  logic                blank_now;
  logic                over_limit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nibble[gi] = bcd_reg[gi*DIGIT_W +: DIGIT_W];
      assign bcd_adj[gi*DIGIT_W +: DIGIT_W] =
        (nibble[gi] >= 4'd5) ? nibble[gi] + 4'd3 : nibble[gi];
      assign hex_flat[gi*7 +: 7] = hex_reg[gi];

      // Shadow is written during the digit walk; the visible copy only at commit.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shadow_reg[gi] <= SEG_BLANK;
          hex_reg[gi]    <= SEG_BLANK;
        end else begin
          if (state_reg == DRIVE && dig_idx_reg == IDX_W'(gi))
            shadow_reg[gi] <= wr_seg;
          if (state_reg == COMMIT)
            hex_reg[gi] <= shadow_reg[gi];
        end
      end
    end
  endgenerate

  assign over_limit = 64'(bus.score) > MAX_VAL;
  assign cur_nibble = sat_reg ? 4'd9 : nibble[dig_idx_reg];
  assign blank_now  = (BLANK_LZ != 0) && (cur_nibble == '0) && !seen_nz_reg
                      && (dig_idx_reg != '0);
  assign wr_seg     = blank_now ? SEG_BLANK : dec_seg;

  seven_segment u_dec (
    .digit (cur_nibble),
    .seg   (dec_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      bin_reg      <= '0;
      bcd_reg      <= '0;
      bit_cnt_reg  <= '0;
      dig_idx_reg  <= '0;
      seen_nz_reg  <= 1'b0;
      sat_reg      <= 1'b0;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.score_valid) begin
            bin_reg     <= bus.score;
            bcd_reg     <= '0;
            bit_cnt_reg <= '0;
            sat_reg     <= over_limit;
            state_reg   <= CONV;
          end
        end
        CONV: begin
          {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
          bit_cnt_reg        <= bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == CNT_W'(SCORE_W - 1)) begin
            dig_idx_reg <= IDX_W'(NUM_DIGITS - 1);
            seen_nz_reg <= 1'b0;
            state_reg   <= DRIVE;
          end
        end
        DRIVE: begin
          if (cur_nibble != '0) seen_nz_reg <= 1'b1;
          if (dig_idx_reg == '0) state_reg <= COMMIT;
          else dig_idx_reg <= dig_idx_reg - 1'b1;
        end
        COMMIT: begin
          done_reg     <= 1'b1;
          overflow_reg <= sat_reg;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ready    = (state_reg == IDLE);
  assign bus.done     = done_reg;
  assign bus.overflow = overflow_reg;
  assign bus.hex_out  = hex_flat;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench for score_display_ctrl: three configurations share one stimulus
// stream; expectations come from a decimal-arithmetic model and are checked per cycle.
module tb_score_display_ctrl;
  import rhythm_hero_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        drv_valid = 1'b0;
  logic [15:0] drv_score = '0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  score_display_ctrl_if #(.SCORE_W(16), .NUM_DIGITS(5)) bus0 ();
  score_display_ctrl_if #(.SCORE_W(16), .NUM_DIGITS(5)) bus1 ();
  score_display_ctrl_if #(.SCORE_W(16), .NUM_DIGITS(3)) bus2 ();

  assign bus0.score = drv_score;  assign bus0.score_valid = drv_valid;
  assign bus1.score = drv_score;  assign bus1.score_valid = drv_valid;
  assign bus2.score = drv_score;  assign bus2.score_valid = drv_valid;

  score_display_ctrl #(.SCORE_W(16), .NUM_DIGITS(5), .BLANK_LZ(1)) u_main (
    .clk(clk), .rst(rst), .bus(bus0));
  score_display_ctrl #(.SCORE_W(16), .NUM_DIGITS(5), .BLANK_LZ(0)) u_nolz (
    .clk(clk), .rst(rst), .bus(bus1));
  score_display_ctrl #(.SCORE_W(16), .NUM_DIGITS(3), .BLANK_LZ(1)) u_three (
    .clk(clk), .rst(rst), .bus(bus2));

  logic [34:0] hex_act [3];
  logic        rdy_act [3];
  logic        done_act[3];
  logic        ov_act  [3];
  assign hex_act[0] = bus0.hex_out;       assign rdy_act[0] = bus0.ready;
  assign hex_act[1] = bus1.hex_out;       assign rdy_act[1] = bus1.ready;
  assign hex_act[2] = 35'(bus2.hex_out);  assign rdy_act[2] = bus2.ready;
  assign done_act[0] = bus0.done;  assign ov_act[0] = bus0.overflow;
  assign done_act[1] = bus1.done;  assign ov_act[1] = bus1.overflow;
  assign done_act[2] = bus2.done;  assign ov_act[2] = bus2.overflow;

  int nd_cfg [3] = '{5, 5, 3};
  int bl_cfg [3] = '{1, 0, 1};
  logic [6:0] seg_tab [10] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4,
                               SEG_5, SEG_6, SEG_7, SEG_8, SEG_9};

  typedef struct {
    int          inst;
    int          cyc;
    logic [34:0] hex;
    logic        ov;
  } exp_t;
  exp_t sb[$];

  int          free_at [3];
  logic [34:0] disp_hex[3];
  logic        disp_ov [3];

  // Display expected for a score, derived from its decimal expansion.
  function automatic logic [35:0] model(input int unsigned s, input int nd, input int bl);
    logic [34:0] h;
    logic        ov;
    int unsigned p;
    int          d;
    h = '0;
    p = 1;
    for (int k = 0; k < nd; k++) p = p * 10;
    ov = (s >= p);
    p = 1;
    for (int k = 0; k < nd; k++) begin
      d = ov ? 9 : int'((s / p) % 10);
      if (!ov && bl != 0 && k != 0 && s < p) h[7*k +: 7] = SEG_BLANK;
      else h[7*k +: 7] = seg_tab[d];
      p = p * 10;
    end
    return {ov, h};
  endfunction

  function automatic logic [34:0] blank_disp(input int nd);
    logic [34:0] h;
    h = '0;
    for (int k = 0; k < nd; k++) h[7*k +: 7] = SEG_BLANK;
    return h;
  endfunction

  task automatic check(input string what, input int i, input logic [34:0] act,
                       input logic [34:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL u%0d.%s at cycle %0d: actual=%h required=%h", i, what, cyc, act, exp);
    end
  endtask

  // Monitor: one sample per cycle, just after the active edge.
  always @(posedge clk) begin
    int idx;
    logic exp_done;
    #1;
    for (int i = 0; i < 3; i++) begin
      idx = -1;
      foreach (sb[j]) if (sb[j].inst == i && sb[j].cyc == cyc) idx = j;
      exp_done = (idx >= 0);
      if (exp_done) begin
        disp_hex[i] = sb[idx].hex;
        disp_ov[i]  = sb[idx].ov;
        sb.delete(idx);
        $display("u%0d done cycle %0d hex=%h ov=%0b", i, cyc, hex_act[i], ov_act[i]);
      end
      check("done",     i, 35'(done_act[i]), 35'(exp_done));
      check("ready",    i, 35'(rdy_act[i]),  35'(cyc >= free_at[i]));
      check("hex_out",  i, hex_act[i],       disp_hex[i]);
      check("overflow", i, 35'(ov_act[i]),   35'(disp_ov[i]));
    end
  end

  // Drive one cycle of inputs (called at a falling edge) and record accepts.
  task automatic tick(input bit v, input logic [15:0] s);
    logic [35:0] r;
    exp_t e;
    drv_valid = v;
    drv_score = s;
    if (v) begin
      for (int i = 0; i < 3; i++) begin
        if (cyc >= free_at[i]) begin
          r = model(int'(s), nd_cfg[i], bl_cfg[i]);
          e.inst = i;
          e.cyc  = cyc + 1 + 16 + nd_cfg[i] + 1;
          e.hex  = r[34:0];
          e.ov   = r[35];
          sb.push_back(e);
          free_at[i] = e.cyc;
          $display("u%0d accept cycle %0d score=%0d", i, cyc + 1, s);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_all_ready();
    while (cyc < free_at[0] || cyc < free_at[1] || cyc < free_at[2]) tick(1'b0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drv_valid = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      free_at[i]  = 0;
      disp_hex[i] = blank_disp(nd_cfg[i]);
      disp_ov[i]  = 1'b0;
    end
    $display("reset asserted at cycle %0d", cyc);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load(input logic [15:0] s);
    wait_all_ready();
    tick(1'b1, s);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      free_at[i]  = 0;
      disp_hex[i] = blank_disp(nd_cfg[i]);
      disp_ov[i]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    load(16'd0);
    load(16'd12345);
    load(16'd1007);
    load(16'd65535);
    repeat (4) tick(1'b0, '0);
    tick(1'b1, 16'd100);
    repeat (9) tick(1'b0, '0);
    tick(1'b1, 16'd100);
    load(16'd4321);
    load(16'd1234);
    load(16'd999);
    repeat (9) tick(1'b0, '0);
    do_reset();
    load(16'd42);
    load(16'd1000);

    for (int t = 0; t < 900; t++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else if ($urandom_range(0, 3) == 0)
        tick(1'b1, ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 1200))
                                               : 16'($urandom_range(0, 65535)));
      else tick(1'b0, '0);
    end
    wait_all_ready();
    repeat (3) tick(1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
